uart_cfg: RTL and testbench
===========================

// Module: uart_cfg
// PURPOSE
//  Runtime-configurable full-duplex UART. Successor to the fixed 8N1 UART: adds runtime baud divisor,
//  parity (none/even/odd), 1/2 stop bits, 5..8 data bits, sticky parity/framing/overrun error flags
//  and parametrised FIFO depth. Sits between the game logic and the board serial pins; self-contained
//  (baud generator, RX/TX FSMs, RX/TX FIFOs internal).
// PARAMETERS
//  DBIT      8   data bits per frame, legal 5..8
//  FIFO_W    4   FIFO address bits; each FIFO holds 2^FIFO_W words
//  DVSR_BIT  16  width of dvsr input / baud counter
// PORTS
//  clk          in   1         system clock
//  reset_n      in   1         asynchronous reset, active low
//  dvsr         in   DVSR_BIT  baud divisor = f_clk/(16*baud); 16 ticks per bit
//  parity_en    in   1         1 = parity bit after data
//  parity_odd   in   1         1 = odd parity, 0 = even (ignored if !parity_en)
//  stop2        in   1         1 = two stop bits on TX
//  rx           in   1         serial input (asynchronous)
//  tx           out  1         serial output
//  wr_uart      in   1         push w_data into TX FIFO
//  w_data       in   DBIT      TX word
//  tx_full      out  1         TX FIFO full
//  tx_empty     out  1         TX FIFO empty
//  tx_busy      out  1         TX frame in progress
//  rd_uart      in   1         pop RX FIFO head
//  r_data       out  DBIT      RX FIFO head (show-ahead)
//  rx_empty     out  1         RX FIFO empty
//  parity_err   out  1         sticky: a frame had bad parity
//  frame_err    out  1         sticky: a frame had stop bit = 0
//  overrun_err  out  1         sticky: a frame arrived with RX FIFO full
//  clr_err      in   1         clears all three sticky flags
// BEHAVIOUR
//  Reset (async, reset_n=0): tx=1, tx_busy=0, FIFOs empty (tx_empty=rx_empty=1, tx_full=0),
//   r_data=0, all error flags 0, baud counter 0, both FSMs IDLE, rx synchroniser =1. Mid-frame reset aborts immediately.
//  Baud tick: counter 0..dvsr-1, 1-clk tick when cnt==dvsr-1, then wraps to 0; if cnt>=dvsr-1 after a dvsr
//   change, counter reloads 0 next clk. dvsr<2: no ticks, FSMs stall.
//  Frame config (parity_en/odd, stop2) latched per direction at start-bit detection/launch; changes mid-frame
//   affect only the next frame. Bits LSB first; parity = ^data (even) or ~^data (odd).
//  RX: rx through 2-flop synchroniser. FSM IDLE->START on synced rx=0. START: after 8 ticks sample; rx=1 ->
//   false start, IDLE, no push; else ->DATA. DATA: sample every 16 ticks, DBIT bits. ->PARITY (if enabled):
//   sample after 16 ticks, mismatch sets parity_err. ->STOP: sample after 16 ticks; 0 sets frame_err.
//   Word pushed to RX FIFO on the stop-sample clk regardless of errors; RX then IDLE (2nd stop bit not checked).
//   Push with FIFO full: word dropped, overrun_err set; push+rd_uart same clk when full: both succeed, no overrun.
//  TX: IDLE with FIFO non-empty -> START next clk: head word popped into shift reg, tx=0, tx_busy=1.
//   START/DATA/PARITY bits each 16 ticks; STOP holds tx=1 for 16 (stop2=0) or 32 ticks, then IDLE,
//   tx_busy=0; a queued word starts the following clk (back-to-back frames, no idle gap).
//   Latency: wr_uart at clk N into empty FIFO, TX idle -> tx_empty=0 at N+1, tx=0 at N+2.
//  FIFOs: wr_uart when tx_full ignored; rd_uart when rx_empty ignored; simultaneous push+pop on a
//   non-empty FIFO keeps count; pointers wrap mod 2^FIFO_W.
//  Errors: flags sticky until clr_err; a set event in the same clk as clr_err wins (flag stays 1).
// TESTING
//  1 dvsr=4, 8N1, write 0xA5 -> tx: 0,1,0,1,0,0,1,0,1,1 each bit 64 clk, tx_busy high 640 clk, tx_empty=1 after.
//  2 dvsr=4, even parity, stop2=1, write 0x03 -> parity bit 0, stop high 128 clk; odd parity -> parity bit 1.
//  3 Loopback rx=tx, odd parity, write 0x00,0xFF,0x5A back-to-back -> r_data 0x00,0xFF,0x5A in order, no flags.
//  4 Drive rx frame 0x41 with stop bit 0 -> 0x41 pushed, frame_err=1; clr_err pulse -> 0; 1-tick rx glitch -> no push.
//  5 Send 17 frames with FIFO_W=4, no reads -> rx_empty=0, first 16 words kept, overrun_err=1 on 17th.
//  6 reset_n=0 mid TX data bit -> tx=1, tx_busy=0, tx_empty=1 same cycle; after release, new write sends cleanly.

Source files
------------

// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable full-duplex UART with internal baud generator,
// RX/TX FSMs and show-ahead RX/TX FIFOs.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   dvsr                               baud divisor, f_clk/(16*baud)
//   parity_en, parity_odd, stop2       frame configuration, latched per frame
//   rx / tx                            serial input / output
//   wr_uart, w_data, tx_full/empty     TX FIFO write side and status
//   tx_busy                            TX frame in progress
//   rd_uart, r_data, rx_empty          RX FIFO read side (show-ahead head)
//   parity_err, frame_err, overrun_err sticky error flags, cleared by clr_err

// Show-ahead FIFO with a registered head word and registered empty/full flags.
// A write while full is accepted only if a read happens in the same clock.
module uart_cfg_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic          rd,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] count, count_n;
    logic          pop_c, push_c;

    assign pop_c    = rd && !empty;
    assign push_c   = wr && (!full || pop_c);
    assign rd_ptr_n = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    assign count_n  = count + CW'(push_c) - CW'(pop_c);

    // Storage array, no reset needed: head is registered and reset separately.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= w_data;
    end

    // Pointers, flags and the head word as it will look after this clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            head   <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            empty  <= (count_n == '0);
            full   <= (count_n == CW'(DEPTH));
            head   <= (push_c && (wr_ptr == rd_ptr_n)) ? w_data : mem[rd_ptr_n];
        end
    end
endmodule

module uart_cfg #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned FIFO_W   = 4,
    parameter int unsigned DVSR_BIT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                stop2,
    input  logic                rx,
    output logic                tx,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    output logic                tx_empty,
    output logic                tx_busy,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err,
    input  logic                clr_err
);
    localparam int unsigned BIT_W = $clog2(DBIT);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

    // Baud generator: one-clock tick every dvsr clocks; dvsr < 2 stalls.
    logic [DVSR_BIT-1:0] b_cnt;
    logic                dvsr_ok, tick_c;
    assign dvsr_ok = (dvsr >= DVSR_BIT'(2));
    assign tick_c  = dvsr_ok && (b_cnt == dvsr - DVSR_BIT'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                   b_cnt <= '0;
        else if (!dvsr_ok || b_cnt >= dvsr - DVSR_BIT'(1)) b_cnt <= '0;
        else                                            b_cnt <= b_cnt + DVSR_BIT'(1);
    end

    // Two-flop synchroniser for the asynchronous rx pin.
    logic rx_s1, rx_sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
        end
    end

    // FIFOs. TX writes while full are dropped; RX uses the FIFO's push+pop rule.
    logic            rx_push_c, rx_full, tx_pop_c;
    logic [DBIT-1:0] tx_head, r_shift, r_shift_n;

    uart_cfg_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .wr(rx_push_c), .w_data(r_shift_n),
        .rd(rd_uart), .head(r_data), .empty(rx_empty), .full(rx_full)
    );
    uart_cfg_fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .wr(wr_uart && !tx_full), .w_data(w_data),
        .rd(tx_pop_c), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    // RX FSM state registers.
    rx_state_t        r_state, r_state_n;
    logic [3:0]       r_tick, r_tick_n;
    logic [BIT_W-1:0] r_bit, r_bit_n;
    logic             r_par_en, r_par_en_n, r_par_odd, r_par_odd_n;
    logic             par_set_c, frm_set_c, ovr_set_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= R_IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
        end else begin
            r_state   <= r_state_n;
            r_tick    <= r_tick_n;
            r_bit     <= r_bit_n;
            r_shift   <= r_shift_n;
            r_par_en  <= r_par_en_n;
            r_par_odd <= r_par_odd_n;
        end
    end

    // RX next state: mid-bit sampling, data shifted in LSB first from the top.
    always_comb begin
        r_state_n   = r_state;
        r_tick_n    = r_tick;
        r_bit_n     = r_bit;
        r_shift_n   = r_shift;
        r_par_en_n  = r_par_en;
        r_par_odd_n = r_par_odd;
        rx_push_c   = 1'b0;
        par_set_c   = 1'b0;
        frm_set_c   = 1'b0;
        case (r_state)
            R_IDLE: if (!rx_sync) begin
                r_state_n   = R_START;
                r_tick_n    = '0;
                r_par_en_n  = parity_en;
                r_par_odd_n = parity_odd;
            end
            R_START: if (tick_c) begin
                if (r_tick == 4'd7) begin
                    r_tick_n  = '0;
                    r_bit_n   = '0;
                    r_state_n = rx_sync ? R_IDLE : R_DATA;
                end else r_tick_n = r_tick + 4'd1;
            end
            R_DATA: if (tick_c) begin
                r_tick_n = r_tick + 4'd1;
                if (r_tick == 4'd15) begin
                    r_shift_n = {rx_sync, r_shift[DBIT-1:1]};
                    if (r_bit == BIT_W'(DBIT - 1))
                        r_state_n = r_par_en ? R_PARITY : R_STOP;
                    else
                        r_bit_n = r_bit + BIT_W'(1);
                end
            end
            R_PARITY: if (tick_c) begin
                r_tick_n = r_tick + 4'd1;
                if (r_tick == 4'd15) begin
                    r_state_n = R_STOP;
                    par_set_c = rx_sync != (r_par_odd ? ~^r_shift : ^r_shift);
                end
            end
            R_STOP: if (tick_c) begin
                r_tick_n = r_tick + 4'd1;
                if (r_tick == 4'd15) begin
                    r_state_n = R_IDLE;
                    rx_push_c = 1'b1;
                    frm_set_c = !rx_sync;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // A push into a full RX FIFO without a same-clock read is an overrun.
    assign ovr_set_c = rx_push_c && rx_full && !rd_uart;

    // Sticky error flags; a set event beats clr_err in the same clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= par_set_c | (parity_err  & ~clr_err);
            frame_err   <= frm_set_c | (frame_err   & ~clr_err);
            overrun_err <= ovr_set_c | (overrun_err & ~clr_err);
        end
    end

    // TX FSM state registers; tx and tx_busy are registered outputs.
    tx_state_t        t_state, t_state_n;
    logic [4:0]       t_tick, t_tick_n;
    logic [BIT_W-1:0] t_bit, t_bit_n;
    logic [DBIT-1:0]  t_shift, t_shift_n;
    logic             t_par, t_par_n, t_par_en, t_par_en_n, t_stop2, t_stop2_n;
    logic             tx_n, tx_busy_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_state  <= T_IDLE;
            t_tick   <= '0;
            t_bit    <= '0;
            t_shift  <= '0;
            t_par    <= 1'b0;
            t_par_en <= 1'b0;
            t_stop2  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            t_state  <= t_state_n;
            t_tick   <= t_tick_n;
            t_bit    <= t_bit_n;
            t_shift  <= t_shift_n;
            t_par    <= t_par_n;
            t_par_en <= t_par_en_n;
            t_stop2  <= t_stop2_n;
            tx       <= tx_n;
            tx_busy  <= tx_busy_n;
        end
    end

    // TX next state: each line level is set on the clock that enters its bit.
    always_comb begin
        t_state_n  = t_state;
        t_tick_n   = t_tick;
        t_bit_n    = t_bit;
        t_shift_n  = t_shift;
        t_par_n    = t_par;
        t_par_en_n = t_par_en;
        t_stop2_n  = t_stop2;
        tx_n       = tx;
        tx_busy_n  = tx_busy;
        tx_pop_c   = 1'b0;
        case (t_state)
            T_IDLE: if (!tx_empty) begin
                tx_pop_c   = 1'b1;
                t_shift_n  = tx_head;
                t_par_n    = parity_odd ? ~^tx_head : ^tx_head;
                t_par_en_n = parity_en;
                t_stop2_n  = stop2;
                t_tick_n   = '0;
                t_state_n  = T_START;
                tx_n       = 1'b0;
                tx_busy_n  = 1'b1;
            end
            T_START: if (tick_c) begin
                t_tick_n = t_tick + 5'd1;
                if (t_tick == 5'd15) begin
                    t_tick_n  = '0;
                    t_bit_n   = '0;
                    t_state_n = T_DATA;
                    tx_n      = t_shift[0];
                end
            end
            T_DATA: if (tick_c) begin
                t_tick_n = t_tick + 5'd1;
                if (t_tick == 5'd15) begin
                    t_tick_n = '0;
                    if (t_bit == BIT_W'(DBIT - 1)) begin
                        t_state_n = t_par_en ? T_PARITY : T_STOP;
                        tx_n      = t_par_en ? t_par : 1'b1;
                    end else begin
                        t_bit_n   = t_bit + BIT_W'(1);
                        t_shift_n = t_shift >> 1;
                        tx_n      = t_shift[1];
                    end
                end
            end
            T_PARITY: if (tick_c) begin
                t_tick_n = t_tick + 5'd1;
                if (t_tick == 5'd15) begin
                    t_tick_n  = '0;
                    t_state_n = T_STOP;
                    tx_n      = 1'b1;
                end
            end
            T_STOP: if (tick_c) begin
                t_tick_n = t_tick + 5'd1;
                if (t_tick == (t_stop2 ? 5'd31 : 5'd15)) begin
                    t_tick_n  = '0;
                    t_state_n = T_IDLE;
                    tx_busy_n = 1'b0;
                end
            end
            default: t_state_n = T_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_cfg.sv
// Testbench for uart_cfg: directed stimulus, expected words/frames queued by
// the stimulus process and checked by independent TX-line and RX-FIFO monitors.
module tb_uart_cfg;
    localparam int BIT_CLK = 64;   // dvsr = 4, 16 ticks per bit

    typedef struct packed {
        logic [11:0] bits;          // bit k = k-th level on the line, start first
        logic [3:0]  n;
    } frame_t;

    logic        clk, reset_n;
    logic [15:0] dvsr;
    logic        parity_en, parity_odd, stop2;
    logic        rx_drv, loop_en, rx_line;
    logic        tx;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        tx_full, tx_empty, tx_busy;
    logic        rd_uart;
    logic [7:0]  r_data;
    logic        rx_empty, parity_err, frame_err, overrun_err, clr_err;

    logic        rd_en, tx_mon_en;
    int          checks, errors;
    frame_t      exp_tx[$];
    logic [7:0]  exp_rx[$];

    assign rx_line = loop_en ? tx : rx_drv;

    uart_cfg #(.DBIT(8), .FIFO_W(4), .DVSR_BIT(16)) dut (
        .clk(clk), .reset_n(reset_n), .dvsr(dvsr),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .rx(rx_line), .tx(tx),
        .wr_uart(wr_uart), .w_data(w_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
        .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX monitor: on each start bit, sample every bit mid-period and compare.
    initial begin
        frame_t      f;
        logic [11:0] got;
        forever begin
            @(negedge clk);
            if (tx_mon_en && reset_n && tx === 1'b0) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected_frame: got start bit expected idle at %0t", $time);
                    f = '{bits: 12'h3FE, n: 4'd10};
                end else begin
                    f = exp_tx.pop_front();
                end
                got = '0;
                for (int k = 0; k < int'(f.n); k++) begin
                    repeat ((k == 0) ? BIT_CLK / 2 - 1 : BIT_CLK) @(negedge clk);
                    got[k] = tx;
                end
                check("tx_frame", 32'(got), 32'(f.bits));
            end
        end
    end

    // RX monitor: whenever a word is presented and reads are enabled, check and pop.
    initial begin
        rd_uart = 1'b0;
        forever begin
            @(negedge clk);
            rd_uart = 1'b0;
            if (rd_en && reset_n && !rx_empty) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected_word: got %0h expected none", r_data);
                end else begin
                    check("rx_data", 32'(r_data), 32'(exp_rx.pop_front()));
                end
                rd_uart = 1'b1;
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic write_byte(input logic [7:0] d);
        wr_uart = 1'b1;
        w_data  = d;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    // Bench-side serial source, 8N1 at BIT_CLK; a bad stop is low for part of the bit.
    task automatic send_rx(input logic [7:0] d, input logic stop_ok);
        rx_drv = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (stop_ok) begin
            rx_drv = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end else begin
            rx_drv = 1'b0;
            repeat (40) @(negedge clk);
            rx_drv = 1'b1;
            repeat (BIT_CLK - 40) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0 || tx_busy || !tx_empty ||
                (rd_en && !rx_empty)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, tx_q %0d rx_q %0d",
                     name, n, exp_tx.size(), exp_rx.size());
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic busy_len(input string name, input int lo, input int hi);
        int cnt;
        cnt = 0;
        while (tx_busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt < lo || cnt > hi) begin
            errors++;
            $display("FAIL %s: got %0d clk expected %0d..%0d", name, cnt, lo, hi);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; dvsr = 16'd4;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        rx_drv = 1'b1; loop_en = 1'b0;
        wr_uart = 1'b0; w_data = '0; clr_err = 1'b0;
        rd_en = 1'b1; tx_mon_en = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_tx", 32'(tx), 32'd1);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        check("reset_tx_empty", 32'(tx_empty), 32'd1);
        check("reset_tx_full", 32'(tx_full), 32'd0);
        check("reset_rx_empty", 32'(rx_empty), 32'd1);
        check("reset_r_data", 32'(r_data), 32'd0);
        check("reset_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: latency, frame bits and busy length.
        exp_tx.push_back('{bits: {2'b00, 1'b1, 8'hA5, 1'b0}, n: 4'd10});
        write_byte(8'hA5);
        check("lat_tx_empty_n1", 32'(tx_empty), 32'd0);
        check("lat_tx_idle_n1", 32'(tx), 32'd1);
        @(negedge clk);
        check("lat_tx_start_n2", 32'(tx), 32'd0);
        check("lat_busy_n2", 32'(tx_busy), 32'd1);
        check("lat_popped_n2", 32'(tx_empty), 32'd1);
        busy_len("busy_8n1", 637, 640);
        check("after_8n1_empty", 32'(tx_empty), 32'd1);
        wait_drain("drain_8n1", 2000);

        // Even parity with two stop bits, then odd parity with one.
        parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
        exp_tx.push_back('{bits: {2'b11, 1'b0, 8'h03, 1'b0}, n: 4'd12});
        write_byte(8'h03);
        @(negedge clk);
        busy_len("busy_8e2", 765, 768);
        parity_odd = 1'b1; stop2 = 1'b0;
        exp_tx.push_back('{bits: {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, n: 4'd11});
        write_byte(8'h03);
        wait_drain("drain_parity", 2000);

        // Odd-parity loopback, three back-to-back words.
        loop_en = 1'b1;
        exp_tx.push_back('{bits: {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, n: 4'd11});
        exp_tx.push_back('{bits: {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, n: 4'd11});
        exp_tx.push_back('{bits: {1'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, n: 4'd11});
        exp_rx.push_back(8'h00);
        exp_rx.push_back(8'hFF);
        exp_rx.push_back(8'h5A);
        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h5A);
        wait_drain("drain_loopback", 4000);
        check("loopback_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        loop_en = 1'b0;

        // Bad stop bit, error clear, and a one-tick glitch.
        parity_en = 1'b0; parity_odd = 1'b0;
        exp_rx.push_back(8'h41);
        send_rx(8'h41, 1'b0);
        repeat (100) @(negedge clk);
        wait_drain("drain_frame_err", 500);
        check("frame_err_set", 32'(frame_err), 32'd1);
        check("frame_err_no_parity", 32'(parity_err), 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("frame_err_cleared", 32'(frame_err), 32'd0);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_push", 32'(rx_empty), 32'd1);
        check("glitch_no_err", 32'({parity_err, frame_err, overrun_err}), 32'd0);

        // Fill the RX FIFO without reading, then overflow it by one frame.
        rd_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_rx.push_back(8'h10 + 8'(i));
            send_rx(8'h10 + 8'(i), 1'b1);
            if (i == 15) check("no_overrun_at_16", 32'(overrun_err), 32'd0);
        end
        repeat (10) @(negedge clk);
        check("overrun_set", 32'(overrun_err), 32'd1);
        check("overrun_rx_not_empty", 32'(rx_empty), 32'd0);
        check("overrun_head", 32'(r_data), 32'h10);
        rd_en = 1'b1;
        wait_drain("drain_overrun", 200);
        check("overrun_drained", 32'(rx_empty), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;

        // Reset in the middle of a TX data bit, then a clean frame.
        tx_mon_en = 1'b0;
        write_byte(8'h3C);
        repeat (200) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_busy", 32'(tx_busy), 32'd0);
        check("midreset_tx_empty", 32'(tx_empty), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        tx_mon_en = 1'b1;
        exp_tx.push_back('{bits: {2'b00, 1'b1, 8'hC3, 1'b0}, n: 4'd10});
        write_byte(8'hC3);
        wait_drain("drain_after_reset", 2000);
        check("after_reset_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
